lz_output_packer: RTL

Byte-to-word packer on the decompression side of the LZ datapath. The LZ decoder emits 1–8 reconstructed bytes per cycle (literals or copy bytes). This block accumulates them in order and presents them to the output stream as full 64-bit words under a valid/ready handshake. A flush request drains a final partial word and marks it as the last word. It is the inverse of the compressor's look-ahead buffer, which takes in 8-byte words and retires bytes individually.

---
 rtl/lz_pkg.sv | 22 ++
 rtl/lz_byte_merge.sv | 36 +++
 rtl/lz_output_packer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lz_pkg.sv
// Shared LZ datapath types: byte/word geometry, byte-count type, flush-state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lz_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;

  typedef logic [BYTE_W*WORD_BYTES-1:0] lz_word_t;
  typedef logic [3:0]                   lz_cnt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } lz_flush_st_t;

  // Byte counts above one word are treated as a full word.
  function automatic lz_cnt_t lz_clamp_cnt(input lz_cnt_t cnt);
    return (cnt > lz_cnt_t'(WORD_BYTES)) ? lz_cnt_t'(WORD_BYTES) : cnt;
  endfunction

endpackage

// File: rtl/lz_byte_merge.sv
// Writes cnt_i bytes of data_i into a byte store at byte offset offset_i; other bytes pass through.
// Latency: purely combinational.
// Backpressure: none; caller guarantees offset_i + cnt_i fits in DEPTH bytes.
module lz_byte_merge
  import lz_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int OFF_BITS = 6
) (
  input  logic [DEPTH*BYTE_W-1:0] store_i,
  input  logic [OFF_BITS-1:0]     offset_i,
  input  lz_word_t                data_i,
  input  lz_cnt_t                 cnt_i,
  output logic [DEPTH*BYTE_W-1:0] store_o
);

  localparam int SW = DEPTH * BYTE_W;

  lz_word_t      lane_mask;
  logic [SW-1:0] data_ext;
  logic [SW-1:0] mask_ext;

  // Build a byte-lane mask for the incoming bytes, slide data and mask to the offset, then overlay.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (k < int'(cnt_i)) begin
        lane_mask[k*BYTE_W +: BYTE_W] = '1;
      end
    end
    data_ext = SW'(data_i)    << (int'(offset_i) * BYTE_W);
    mask_ext = SW'(lane_mask) << (int'(offset_i) * BYTE_W);
    store_o  = (store_i & ~mask_ext) | (data_ext & mask_ext);
  end

endmodule

// File: rtl/lz_output_packer.sv
// Packs 1..8 decoded bytes per cycle into 64-bit output words; flush drains a final partial word.
// Latency: 1 cycle from the edge accepting the 8th byte to out_valid.
// Backpressure: out_ready low holds the word; in_ready drops once fewer than 8 bytes of room remain.
module lz_output_packer
  import lz_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [3:0]          in_count,
  input  logic [63:0]         in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic                out_valid,
  output logic [63:0]         out_data,
  output logic [3:0]          out_bytes,
  output logic                out_last,
  input  logic                out_ready,
  output logic [CNT_BITS-1:0] level,
  output logic                flush_busy,
  output logic                flush_done
);

  localparam int SW = DEPTH * BYTE_W;
  localparam logic [CNT_BITS-1:0] RDY_MAX  = CNT_BITS'(DEPTH - WORD_BYTES);
  localparam logic [CNT_BITS-1:0] WORD_LVL = CNT_BITS'(WORD_BYTES);

  lz_flush_st_t        state_q, state_d;
  logic [CNT_BITS-1:0] level_q, level_d;
  logic                flush_done_q, flush_done_d;
  logic [SW-1:0]       store_q, store_d;

  logic [SW-1:0]       store_shift;
  logic [CNT_BITS-1:0] offset;
  lz_cnt_t             acc_cnt;
  lz_cnt_t             rem_cnt;
  logic                xfer;

  // Output-side view, derived only from registered state (plus reset for in_ready).
  always_comb begin
    flush_busy = (state_q == ST_FLUSH);
    in_ready   = (level_q <= RDY_MAX) && !flush_busy && reset;
    out_valid  = (level_q >= WORD_LVL) || (flush_busy && (level_q != '0));
    out_bytes  = '0;
    out_data   = '0;
    if (out_valid) begin
      out_bytes = (level_q >= WORD_LVL) ? lz_cnt_t'(WORD_BYTES) : level_q[3:0];
    end
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (lz_cnt_t'(k) < out_bytes) begin
        out_data[k*BYTE_W +: BYTE_W] = store_q[k*BYTE_W +: BYTE_W];
      end
    end
    out_last = flush_busy && out_valid && (level_q <= WORD_LVL);
  end

  // Retire the transferred word from the bottom of the store, then size the incoming append.
  always_comb begin
    xfer        = out_valid && out_ready;
    rem_cnt     = xfer ? out_bytes : '0;
    acc_cnt     = (in_valid && in_ready) ? lz_clamp_cnt(in_count) : '0;
    offset      = level_q - CNT_BITS'(rem_cnt);
    store_shift = store_q >> {rem_cnt, 3'b000};
    level_d     = offset + CNT_BITS'(acc_cnt);
  end

  // New bytes land directly behind whatever survives this cycle's removal.
  lz_byte_merge #(
    .DEPTH    (DEPTH),
    .OFF_BITS (CNT_BITS)
  ) u_merge (
    .store_i  (store_shift),
    .offset_i (offset),
    .data_i   (in_data),
    .cnt_i    (acc_cnt),
    .store_o  (store_d)
  );

  // Flush sequencing: enter FLUSH only if something will be left to drain, otherwise complete at once.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          if (level_d != '0) begin
            state_d = ST_FLUSH;
          end else begin
            flush_done_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (xfer && out_last) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end
    endcase
  end

  // State registers; store contents need no reset because level masks every stale byte.
  always_ff @(posedge clock) begin
    store_q <= store_d;
    if (!reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign level      = level_q;
  assign flush_done = flush_done_q;

endmodule
